semaforo: RTL and testbench
===========================

# semaforo

Two-way traffic-light controller for a single intersection. Light A controls the main road and light B controls the cross road. A Moore FSM runs a fixed four-phase cycle with programmable phase lengths. A request button `bt` cuts the current green phase short. The block is standalone and driven only by the system clock, reset and the button.

## Interface
- `VERDE`, default 8'd1: green phase length in cycles (valid 1..255).
- `AMARELO`, default 8'd3: yellow phase length in cycles (valid 1..255), used for both lights.
- `VERMELHO`, default 8'd2: cross-road green phase length in cycles (valid 1..255).
- `clk`, input, 1 bit: system clock; all state changes on its rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-low.
- `bt`, input, 1 bit: request button, active-high, sampled on `clk` rising edge.
- `A`, output, 3 bits: light A, one-hot {red, yellow, green}.
  - 3'b001 = green, 3'b010 = yellow, 3'b100 = red.
- `B`, output, 3 bits: light B, same encoding as `A`.

## Operation
- States, in cycle order, with outputs and lengths:
  - AG: `A` green, `B` red, lasts `VERDE` cycles.
  - AY: `A` yellow, `B` red, lasts `AMARELO` cycles.
  - BG: `A` red, `B` green, lasts `VERMELHO` cycles.
  - BY: `A` red, `B` yellow, lasts `AMARELO` cycles.
  - After BY the FSM returns to AG.
- Light A is therefore red for `VERMELHO` + `AMARELO` cycles per cycle.
- Phase counter:
  - 8 bits, loaded with (length − 1) on entry to each state.
  - Decrements each cycle; the state advances on the edge where the counter is 0.
- A length parameter of 0 is treated as 1; no state ever lasts zero cycles.
- Button:
  - If `bt` = 1 at a rising edge while in AG or BG, the next state is AY or BY respectively, regardless of the counter.
  - `bt` is ignored in AY and BY; requests are not latched or queued.
  - Holding `bt` high shortens every green phase to 1 cycle.
- Safety invariants:
  - `A` and `B` are never both non-red.
  - Every output is always exactly one-hot.
  - Every green phase is followed by that light's yellow phase, never directly by red.
- Outputs decode from the state register only (Moore); `bt` never affects outputs combinationally.
- Unreachable state encodings recover to AG on the next edge, with the counter loaded from `VERDE`.

## Timing
- Reset:
  - `rst` = 0 immediately, with no clock needed, sets state AG with the counter loaded to `VERDE` − 1.
  - Outputs during and after reset: `A` = 3'b001, `B` = 3'b100.
- Reset takes effect asynchronously mid-phase; the cycle restarts from AG.
- The first rising edge with `rst` = 1 counts as cycle 1 of AG.
- Latency: a change of state is visible on `A`/`B` in the same edge's output update; there is no extra pipeline stage.
- `bt` seen at edge N in AG or BG: yellow is visible after edge N.
- Simultaneous events:
  - Counter reaching 0 together with `bt` = 1 gives a single normal advance.
  - `rst` low overrides everything.
- Defaults give a full cycle of 1 + 3 + 2 + 3 = 9 clocks.

## Test plan
- Reset with defaults: hold `rst` = 0 with no clock edges.
  - Required: `A` = 001, `B` = 100.
  - After release, the per-edge sequence (A,B) repeats every 9 edges: AG×1, AY×3, BG×2, BY×3.
- Early green end: `VERDE` = 5; pulse `bt` for one edge at AG cycle 2.
  - Required: `A` = 010 after that edge; AY still lasts 3 cycles.
- Cross-road request: `VERMELHO` = 6; `bt` high at BG cycle 1.
  - Required: `B` = 010 after that edge; `A` stays 100 until BY ends.
- Button ignored in yellow: `bt` high throughout AY.
  - Required: AY lasts exactly `AMARELO` cycles.
- Reset mid-BG: drop `rst` asynchronously between edges.
  - Required: `A` = 001 and `B` = 100 immediately; a fresh AG follows release.
- Boundaries: `VERDE` = 0 behaves as 1.
  - With `AMARELO` = 255, AY lasts exactly 255 cycles.
  - The safety invariant is checked every cycle across a random `bt` run.

Source files
------------

// File: rtl/semaforo.sv
// semaforo: two-way traffic-light controller.
// Fixed four-phase Moore FSM with a button that cuts green short.
module semaforo #(
    parameter logic [7:0] VERDE    = 8'd1,
    parameter logic [7:0] AMARELO  = 8'd3,
    parameter logic [7:0] VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [1:0] AG = 2'd0;
    localparam logic [1:0] AY = 2'd1;
    localparam logic [1:0] BG = 2'd2;
    localparam logic [1:0] BY = 2'd3;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // A zero length behaves as one cycle, so its reload value is also 0.
    localparam logic [7:0] LOAD_G =
        (VERDE == 8'd0) ? 8'd0 : VERDE - 8'd1;
    localparam logic [7:0] LOAD_Y =
        (AMARELO == 8'd0) ? 8'd0 : AMARELO - 8'd1;
    localparam logic [7:0] LOAD_R =
        (VERMELHO == 8'd0) ? 8'd0 : VERMELHO - 8'd1;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       done;

    assign done = (cnt == 8'd0);

    // Next-state and counter reload: advance at count 0, or on bt in green.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 8'd1;
        case (state)
            AG: begin
                if (bt || done) begin
                    state_nx = AY;
                    cnt_nx   = LOAD_Y;
                end
            end
            AY: begin
                if (done) begin
                    state_nx = BG;
                    cnt_nx   = LOAD_R;
                end
            end
            BG: begin
                if (bt || done) begin
                    state_nx = BY;
                    cnt_nx   = LOAD_Y;
                end
            end
            BY: begin
                if (done) begin
                    state_nx = AG;
                    cnt_nx   = LOAD_G;
                end
            end
            default: begin
                state_nx = AG;
                cnt_nx   = LOAD_G;
            end
        endcase
    end

    // State and phase counter registers; reset restarts the cycle at AG.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= AG;
            cnt   <= LOAD_G;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Light decode from the state register only.
    always_comb begin
        A = RED;
        B = RED;
        case (state)
            AG:      A = GREEN;
            AY:      A = YELLOW;
            BG:      B = GREEN;
            BY:      B = YELLOW;
            default: begin
                A = RED;
                B = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// tb_semaforo: directed checks of the semaforo traffic-light FSM.
// Four instances cover default, short/long phase parameter sets.
module tb_semaforo;

    localparam logic [5:0] S_AG = 6'b001_100;
    localparam logic [5:0] S_AY = 6'b010_100;
    localparam logic [5:0] S_BG = 6'b100_001;
    localparam logic [5:0] S_BY = 6'b100_010;

    logic       clk;
    logic       rst0, rst1, rst2, rst3;
    logic       bt0, bt1, bt2, bt3;
    logic [2:0] a0, a1, a2, a3;
    logic [2:0] b0, b1, b2, b3;

    int checks;
    int errors;

    logic [5:0] seq [9];

    semaforo u0 (
        .clk(clk), .rst(rst0), .bt(bt0), .A(a0), .B(b0)
    );

    semaforo #(.VERDE(8'd5)) u1 (
        .clk(clk), .rst(rst1), .bt(bt1), .A(a1), .B(b1)
    );

    semaforo #(.VERMELHO(8'd6)) u2 (
        .clk(clk), .rst(rst2), .bt(bt2), .A(a2), .B(b2)
    );

    semaforo #(.VERDE(8'd0), .AMARELO(8'd255)) u3 (
        .clk(clk), .rst(rst3), .bt(bt3), .A(a3), .B(b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(
        input string      tag,
        input logic [5:0] got,
        input logic [5:0] exp
    );
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] pa, pb;
        logic       ok;

        checks = 0;
        errors = 0;
        seq = '{S_AY, S_AY, S_AY, S_BG, S_BG,
                S_BY, S_BY, S_BY, S_AG};
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        bt0 = 1'b0; bt1 = 1'b0; bt2 = 1'b0; bt3 = 1'b0;

        // Reset state before any clock edge.
        #2;
        chk("rst0_noclk", {a0, b0}, S_AG);
        chk("rst1_noclk", {a1, b1}, S_AG);
        chk("rst2_noclk", {a2, b2}, S_AG);
        chk("rst3_noclk", {a3, b3}, S_AG);

        tick();
        chk("rst0_held", {a0, b0}, S_AG);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

        // Default cycle: two full 9-edge periods.
        for (int k = 0; k < 18; k++) begin
            tick();
            chk($sformatf("cycle_e%0d", k + 1), {a0, b0}, seq[k % 9]);
        end

        // bt held through AY is ignored.
        bt0 = 1'b1;
        tick();
        chk("bty_e1", {a0, b0}, S_AY);
        tick();
        chk("bty_e2", {a0, b0}, S_AY);
        tick();
        chk("bty_e3", {a0, b0}, S_AY);
        tick();
        chk("bty_end", {a0, b0}, S_BG);
        bt0 = 1'b0;

        // Asynchronous reset in the middle of BG.
        tick();
        chk("mid_bg", {a0, b0}, S_BG);
        #2;
        rst0 = 1'b0;
        #1;
        chk("async_rst", {a0, b0}, S_AG);
        tick();
        chk("async_held", {a0, b0}, S_AG);
        rst0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("fresh_e%0d", k + 1), {a0, b0}, seq[k]);
        end

        // Early green end with VERDE=5: bt at AG cycle 2.
        rst1 = 1'b0;
        tick();
        rst1 = 1'b1;
        tick();
        chk("early_c1", {a1, b1}, S_AG);
        bt1 = 1'b1;
        tick();
        chk("early_bt", {a1, b1}, S_AY);
        bt1 = 1'b0;
        tick();
        chk("early_y2", {a1, b1}, S_AY);
        tick();
        chk("early_y3", {a1, b1}, S_AY);
        tick();
        chk("early_bg", {a1, b1}, S_BG);

        // Cross-road request with VERMELHO=6 at BG cycle 1.
        rst2 = 1'b0;
        tick();
        rst2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cross_ay", {a2, b2}, S_AY);
        end
        tick();
        chk("cross_bg", {a2, b2}, S_BG);
        bt2 = 1'b1;
        tick();
        chk("cross_bt", {a2, b2}, S_BY);
        bt2 = 1'b0;
        tick();
        chk("cross_by2", {a2, b2}, S_BY);
        tick();
        chk("cross_by3", {a2, b2}, S_BY);
        tick();
        chk("cross_ag", {a2, b2}, S_AG);

        // VERDE=0 acts as 1; AMARELO=255 gives 255-cycle yellows.
        rst3 = 1'b0;
        tick();
        rst3 = 1'b1;
        for (int k = 0; k < 255; k++) begin
            tick();
            chk($sformatf("long_ay%0d", k + 1), {a3, b3}, S_AY);
        end
        tick();
        chk("long_bg1", {a3, b3}, S_BG);
        tick();
        chk("long_bg2", {a3, b3}, S_BG);
        for (int k = 0; k < 255; k++) begin
            tick();
            chk($sformatf("long_by%0d", k + 1), {a3, b3}, S_BY);
        end
        tick();
        chk("zero_ag", {a3, b3}, S_AG);
        tick();
        chk("zero_ay", {a3, b3}, S_AY);

        // Random bt: safety invariants every cycle.
        pa = a0;
        pb = b0;
        for (int k = 0; k < 300; k++) begin
            bt0 = 1'($urandom_range(0, 1));
            tick();
            ok = $onehot(a0) && $onehot(b0)
                 && (a0 == 3'b100 || b0 == 3'b100);
            if (pa == 3'b001 && a0 != 3'b001)
                ok = ok && (a0 == 3'b010);
            if (pb == 3'b001 && b0 != 3'b001)
                ok = ok && (b0 == 3'b010);
            chk($sformatf("inv_%0d", k), {5'd0, ok}, 6'd1);
            pa = a0;
            pb = b0;
        end
        bt0 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
